ps2_frame_rx: RTL and testbench

//  PS/2 device-to-host serial receiver feeding the keyboard decoder.
//  - Samples ps2c/ps2d from the Nexys4 USB-HID bridge; deglitches ps2c; deserialises 11-bit frames.
//  - Presents each valid scan-code byte on dout with a one-cycle rx_done_tick.
//  - Flags malformed or stalled frames on frame_err.

---
 rtl/ps2_frame_rx_pkg.sv | 22 ++
 rtl/ps2_frame_rx_clk_filter.sv | 59 +++++
 rtl/ps2_frame_rx.sv | 143 ++++++++++++++
 tb/tb_ps2_frame_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
// Frame parity checking is compiled in by defining PS2_PARITY_CHECK_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // True when the data byte and its parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx_clk_filter.sv
// Input conditioning for the PS/2 lines: 2-FF synchronisers, a FILTER_LEN
// sample glitch filter on ps2c, and a falling-edge pulse on the filtered clock.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic clk_filt,
  output logic fall_edge,
  output logic data_sync
);

  logic                  c_meta_q, c_sync_q;
  logic                  d_meta_q, d_sync_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  fall_q, fall_d;

  // Filtered clock only moves once the whole sample history agrees.
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], c_sync_q};
    if (&hist_d) begin
      filt_d = 1'b1;
    end else if (~|hist_d) begin
      filt_d = 1'b0;
    end else begin
      filt_d = filt_q;
    end
    fall_d = filt_q & ~filt_d;
  end

  // Synchronisers, history and edge registers; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      hist_q   <= '1;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      c_meta_q <= ps2c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
      hist_q   <= hist_d;
      filt_q   <= filt_d;
      fall_q   <= fall_d;
    end
  end

  assign clk_filt  = filt_q;
  assign fall_edge = fall_q;
  assign data_sync = d_sync_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Define PS2_PARITY_CHECK_EN to reject frames with a bad parity bit.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2d,
  input  logic                 ps2c,
  input  logic                 rx_en,
  output logic                 rx_done_tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 frame_err
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                  clk_filt_s;
  logic                  fall_s;
  logic                  sd_s;
  logic [FRAME_BITS-2:0] shift_in_s;
  logic                  frame_ok_s;

  state_e                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic [DATA_BITS-1:0]  dout_q, dout_d;
  logic                  tick_q, tick_d;
  logic                  err_q, err_d;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .clk_filt  (clk_filt_s),
    .fall_edge (fall_s),
    .data_sync (sd_s)
  );

  // Shifted view after the current edge: [9]=stop, [8]=parity, [7:0]=data.
  assign shift_in_s = {sd_s, shift_q[FRAME_BITS-2:1]};

  // Frame verdict on the word that will sit in the shift register during DONE.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok_s = shift_in_s[9] & odd_parity_ok(shift_in_s[7:0], shift_in_s[8]);
`else
    frame_ok_s = shift_in_s[9];
`endif
  end

  // Next-state logic. The DONE verdict is registered on the stop-bit edge so
  // the tick/error pulse and the new dout are visible exactly while in DONE.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    tick_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall_s && rx_en && !sd_s) begin
          state_d   = DATA;
          bit_cnt_d = 4'd9;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (fall_s) begin
          shift_d  = shift_in_s;
          to_cnt_d = '0;
          if (bit_cnt_q == 4'd0) begin
            state_d = DONE;
            if (frame_ok_s) begin
              tick_d = 1'b1;
              dout_d = shift_in_s[DATA_BITS-1:0];
            end else begin
              err_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d     = 1'b1;
          state_d   = IDLE;
          shift_d   = '0;
          to_cnt_d  = '0;
          bit_cnt_d = 4'd0;
        end else begin
          to_cnt_d = to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      to_cnt_q  <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign rx_done_tick = tick_q;
  assign dout         = dout_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed self-checking bench for ps2_frame_rx (timing scaled: 40-cycle half-period, 200-cycle timeout).
module tb_ps2_frame_rx;

  localparam int HALF    = 40;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2d;
  logic       ps2c;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [7:0] tick_dout = 8'h00;
  int t0, e0;

  ps2_frame_rx #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .rx_en        (rx_en),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      tick_cnt  <= tick_cnt + 1;
      tick_dout <= dout;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (rx_done_tick && frame_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // frame vector: {stop, parity, data, start}
  function automatic logic [10:0] mk(input logic stop, input logic par, input logic [7:0] d);
    return {stop, par, d, 1'b0};
  endfunction

  // Send the first nbits of frame LSB first; rx_en drops after bit drop_after's low phase.
  task automatic send_frame(input logic [10:0] frame, input int nbits, input int drop_after);
    for (int i = 0; i < nbits; i++) begin
      ps2d = frame[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i == drop_after) rx_en = 1'b0;
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  task automatic snap();
    t0 = tick_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    wait_cycles(5);
    check_eq("reset_dout", 32'(dout), 32'h00);
    check_eq("reset_tick", 32'(rx_done_tick), 32'h0);
    check_eq("reset_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    wait_cycles(20);

    // good frame 0x1C, parity 0
    snap();
    send_frame(mk(1'b1, 1'b0, 8'h1C), 11, -1);
    wait_cycles(2 * HALF);
    check_eq("f1c_ticks", 32'(tick_cnt - t0), 32'd1);
    check_eq("f1c_errs", 32'(err_cnt - e0), 32'd0);
    check_eq("f1c_dout", 32'(dout), 32'h1C);
    check_eq("f1c_dout_at_tick", 32'(tick_dout), 32'h1C);

    // 0x1D with wrong parity 0
    snap();
    send_frame(mk(1'b1, 1'b0, 8'h1D), 11, -1);
    wait_cycles(2 * HALF);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("par_ticks", 32'(tick_cnt - t0), 32'd0);
    check_eq("par_errs", 32'(err_cnt - e0), 32'd1);
    check_eq("par_dout", 32'(dout), 32'h1C);
`else
    check_eq("par_ticks", 32'(tick_cnt - t0), 32'd1);
    check_eq("par_errs", 32'(err_cnt - e0), 32'd0);
    check_eq("par_dout", 32'(dout), 32'h1D);
`endif

    // 0x23 with stop bit 0
    snap();
    send_frame(mk(1'b0, 1'b0, 8'h23), 11, -1);
    wait_cycles(2 * HALF);
    check_eq("stop_ticks", 32'(tick_cnt - t0), 32'd0);
    check_eq("stop_errs", 32'(err_cnt - e0), 32'd1);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("stop_dout", 32'(dout), 32'h1C);
`else
    check_eq("stop_dout", 32'(dout), 32'h1D);
`endif

    // start + 4 data bits, then the clock stalls high
    snap();
    send_frame(mk(1'b1, 1'b0, 8'h3C), 5, -1);
    wait_cycles(TIMEOUT - HALF - 5);
    check_eq("to_early_errs", 32'(err_cnt - e0), 32'd0);
    wait_cycles(60);
    check_eq("to_errs", 32'(err_cnt - e0), 32'd1);
    check_eq("to_ticks", 32'(tick_cnt - t0), 32'd0);
    snap();
    send_frame(mk(1'b1, 1'b1, 8'hF0), 11, -1);
    wait_cycles(2 * HALF);
    check_eq("f0_ticks", 32'(tick_cnt - t0), 32'd1);
    check_eq("f0_errs", 32'(err_cnt - e0), 32'd0);
    check_eq("f0_dout", 32'(dout), 32'hF0);

    // 3-cycle low glitch on ps2c with data low
    snap();
    ps2d = 1'b0;
    wait_cycles(10);
    ps2c = 1'b0;
    wait_cycles(3);
    ps2c = 1'b1;
    wait_cycles(30);
    ps2d = 1'b1;
    wait_cycles(10);
    check_eq("glitch_ticks", 32'(tick_cnt - t0), 32'd0);
    check_eq("glitch_errs", 32'(err_cnt - e0), 32'd0);
    send_frame(mk(1'b1, 1'b0, 8'h1C), 11, -1);
    wait_cycles(2 * HALF);
    check_eq("glitch_next_ticks", 32'(tick_cnt - t0), 32'd1);
    check_eq("glitch_next_dout", 32'(dout), 32'h1C);

    // reset in the middle of a frame
    snap();
    send_frame(mk(1'b1, 1'b0, 8'h5A), 6, -1);
    reset = 1'b1;
    wait_cycles(3);
    check_eq("midrst_dout", 32'(dout), 32'h00);
    check_eq("midrst_tick", 32'(rx_done_tick), 32'h0);
    check_eq("midrst_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    wait_cycles(2 * HALF);
    check_eq("midrst_no_pulse", 32'((tick_cnt - t0) + (err_cnt - e0)), 32'd0);
    check_eq("midrst_dout_after", 32'(dout), 32'h00);
    snap();
    send_frame(mk(1'b0 ^ 1'b1, 1'b0, 8'h23), 11, -1);
    wait_cycles(2 * HALF);
    check_eq("f23_ticks", 32'(tick_cnt - t0), 32'd1);
    check_eq("f23_dout", 32'(dout), 32'h23);

    // rx_en low for a whole frame
    snap();
    rx_en = 1'b0;
    send_frame(mk(1'b1, 1'b0, 8'h1C), 11, -1);
    wait_cycles(2 * HALF);
    check_eq("rxen_off_ticks", 32'(tick_cnt - t0), 32'd0);
    check_eq("rxen_off_errs", 32'(err_cnt - e0), 32'd0);
    check_eq("rxen_off_dout", 32'(dout), 32'h23);

    // rx_en dropped right after the start bit
    rx_en = 1'b1;
    wait_cycles(10);
    snap();
    send_frame(mk(1'b1, 1'b1, 8'h5A), 11, 0);
    wait_cycles(2 * HALF);
    check_eq("rxen_drop_ticks", 32'(tick_cnt - t0), 32'd1);
    check_eq("rxen_drop_dout", 32'(dout), 32'h5A);
    rx_en = 1'b1;

    check_eq("tick_err_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
